// File: rtl/kpg_carry_resolve.sv
// kpg_carry_resolve: iterative Kogge-Stone carry resolution over a packed
// per-bit kill/propagate/generate vector. One prefix level is applied per
// clock; the registered sum/carry-out are presented with a one-cycle done.
module kpg_carry_resolve #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] kpg_in,
  input  logic               cin,
  output logic               ready,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               err
);

  localparam int STEPS = $clog2(WIDTH + 1);
  localparam int SW    = $clog2(STEPS);
  localparam int EW    = 2 * (WIDTH + 1);

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_G = 2'b01;
  localparam logic [1:0] KPG_P = 2'b10;
  localparam logic [1:0] KPG_X = 2'b11;

  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Prefix operator: a propagating upper span takes the lower span's status.
  function automatic logic [1:0] combine(input logic [1:0] upper, input logic [1:0] lower);
    return (upper == KPG_P) ? lower : upper;
  endfunction

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [EW-1:0]   e_q, e_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  logic [EW-1:0]    e_cap_s;
  logic [WIDTH-1:0] p_cap_s;
  logic             err_cap_s;
  logic [1:0]       code_s;

  logic [31:0]      dist_s;
  logic [EW-1:0]    lower_s;
  logic [EW-1:0]    e_lvl_s;
  logic [WIDTH-1:0] sum_lvl_s;

  // Build the capture image: e[0] carries cin, e[j+1] is bit j's code with 11 folded to G.
  always_comb begin
    e_cap_s   = {EW{1'b0}};
    p_cap_s   = {WIDTH{1'b0}};
    err_cap_s = 1'b0;
    code_s    = KPG_K;
    e_cap_s[1:0] = cin ? KPG_G : KPG_K;
    for (int j = 0; j < WIDTH; j++) begin
      code_s     = kpg_in[2*j +: 2];
      p_cap_s[j] = kpg_in[2*j+1];
      if (code_s == KPG_X) begin
        e_cap_s[2*(j+1) +: 2] = KPG_G;
        err_cap_s             = 1'b1;
      end else begin
        e_cap_s[2*(j+1) +: 2] = code_s;
      end
    end
  end

  // One prefix level at distance 2^step; entries below the distance are left alone.
  always_comb begin
    dist_s    = 32'd1 << step_q;
    lower_s   = e_q << (2 * dist_s);
    e_lvl_s   = e_q;
    sum_lvl_s = {WIDTH{1'b0}};
    for (int j = 0; j <= WIDTH; j++) begin
      if (32'(j) >= dist_s) begin
        e_lvl_s[2*j +: 2] = combine(e_q[2*j +: 2], lower_s[2*j +: 2]);
      end else begin
        e_lvl_s[2*j +: 2] = e_q[2*j +: 2];
      end
    end
    for (int j = 0; j < WIDTH; j++) begin
      sum_lvl_s[j] = p_q[j] ^ (e_lvl_s[2*j +: 2] == KPG_G);
    end
  end

  // Next-state and output logic for the IDLE/RUN controller.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    e_d     = e_q;
    p_d     = p_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    ready_d = ready_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          e_d     = e_cap_s;
          p_d     = p_cap_s;
          err_d   = err_cap_s;
          step_d  = {SW{1'b0}};
          state_d = S_RUN;
          ready_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_RUN: begin
        e_d = e_lvl_s;
        if (step_q == LAST_STEP) begin
          sum_d   = sum_lvl_s;
          cout_d  = (e_lvl_s[EW-1 -: 2] == KPG_G);
          done_d  = 1'b1;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= {SW{1'b0}};
      e_q     <= {EW{1'b0}};
      p_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      e_q     <= e_d;
      p_q     <= p_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_kpg_carry_resolve.sv
// Directed and random bench for kpg_carry_resolve (WIDTH=32, 6 levels).
module tb_kpg_carry_resolve;

  localparam int WIDTH = 32;
  localparam int LAT   = 7;

  logic               clk;
  logic               rst;
  logic               start;
  logic [2*WIDTH-1:0] kpg_in;
  logic               cin;
  logic               ready;
  logic               done;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               err;

  int vectors     = 0;
  int miscompares = 0;

  kpg_carry_resolve #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kpg_in (kpg_in),
    .cin    (cin),
    .ready  (ready),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] kpg_of(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] ^ b[i])      r[2*i +: 2] = 2'b10;
      else if (a[i] & b[i]) r[2*i +: 2] = 2'b01;
      else                  r[2*i +: 2] = 2'b00;
    end
    return r;
  endfunction

  // Called at a negedge: drive a request so it is captured at the next posedge.
  task automatic start_op(input logic [63:0] k, input logic c);
    kpg_in = k;
    cin    = c;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Counts capture-inclusive edges until done, bounded.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input int lat, input logic [31:0] es,
                          input logic ec, input logic ee);
    logic bad;
    check({tag, "_done"},  {63'd0, done}, 64'd1);
    check({tag, "_lat"},   64'(lat), 64'(LAT));
    check({tag, "_sum"},   {32'd0, sum}, {32'd0, es});
    check({tag, "_cout"},  {63'd0, cout}, {63'd0, ec});
    check({tag, "_err"},   {63'd0, err}, {63'd0, ee});
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    bad = 1'b0;
    for (int j = 0; j <= WIDTH; j++) begin
      if (dut.e_q[2*j +: 2] == 2'b10) bad = 1'b1;
    end
    check({tag, "_noP"}, {63'd0, bad}, 64'd0);
  endtask

  task automatic op(input string tag, input logic [63:0] k, input logic c,
                    input logic [31:0] es, input logic ec, input logic ee);
    int lat;
    start_op(k, c);
    wait_done(1, lat);
    check_op(tag, lat, es, ec, ee);
  endtask

  initial begin
    int lat;
    int spurious;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rsum;

    rst    = 1'b1;
    start  = 1'b0;
    kpg_in = 64'd0;
    cin    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_done",  {63'd0, done},  64'd0);
    check("rst_sum",   {32'd0, sum},   64'd0);
    check("rst_cout",  {63'd0, cout},  64'd0);
    check("rst_err",   {63'd0, err},   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 0xFFFFFFFF + 1: G at bit 0, P elsewhere
    op("ones_plus_one", kpg_of(32'hFFFF_FFFF, 32'h0000_0001), 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    @(negedge clk);
    check("done_pulse", {63'd0, done}, 64'd0);

    // All P with cin: longest ripple
    op("allP_cin", kpg_of(32'hFFFF_FFFF, 32'h0000_0000), 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    op("zero_cin", kpg_of(32'h0000_0000, 32'h0000_0000), 1'b1, 32'h0000_0001, 1'b0, 1'b0);

    // Back-to-back: second start lands in the first done cycle
    @(negedge clk);
    op("mixed", kpg_of(32'h1234_5678, 32'h8765_4321), 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    op("b2b_msb", kpg_of(32'h8000_0000, 32'h8000_0000), 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Illegal 11 on bit 5: carry into bit 6, p[5]=1 from the raw code
    @(negedge clk);
    op("illegal", 64'h0000_0000_0000_0C00, 1'b0, 32'h0000_0060, 1'b0, 1'b1);
    op("err_clear", kpg_of(32'h0000_0001, 32'h0000_0002), 1'b0, 32'h0000_0003, 1'b0, 1'b0);

    // Reset at RUN step 3 aborts without done
    @(negedge clk);
    start_op(kpg_of(32'h0F0F_0F0F, 32'h0101_0101), 1'b0);
    repeat (3) @(negedge clk);
    check("abort_step", 64'(dut.step_q), 64'd3);
    rst = 1'b1;
    #1;
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_done",  {63'd0, done},  64'd0);
    check("abort_sum",   {32'd0, sum},   64'd0);
    check("abort_cout",  {63'd0, cout},  64'd0);
    check("abort_err",   {63'd0, err},   64'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    check("abort_nodone", 64'(spurious), 64'd0);
    op("after_abort", kpg_of(32'h0F0F_0F0F, 32'h0101_0101), 1'b0, 32'h1010_1010, 1'b0, 1'b0);

    // start while busy at step 2 is ignored
    @(negedge clk);
    start_op(kpg_of(32'hDEAD_BEEF, 32'h1111_1111), 1'b1);
    repeat (2) @(negedge clk);
    check("busy_ready", {63'd0, ready}, 64'd0);
    kpg_in = kpg_of(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cin    = 1'b0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(4, lat);
    check_op("busy_ignore", lat, 32'hEFBE_D001, 1'b0, 1'b0);

    // Random regression against a+b+cin, back-to-back
    for (int n = 0; n < 2000; n++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rsum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      op("random", kpg_of(ra, rb), rc, rsum[31:0], rsum[32], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
